delay_line_ctrl: RTL and testbench

DELAY_LINE_CTRL -- requirements
Module: delay_line_ctrl

---
 rtl/pedal_mem_pkg.sv | 24 ++
 rtl/sample_sat_add.sv | 37 +++
 rtl/delay_line_ctrl.sv | 151 +++++++++++++++
 tb/tb_delay_line_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pedal_mem_pkg.sv
// Shared types and defaults for the echo/loop delay-line controller.
// Holds the controller FSM encoding, the transaction modes and the 16-bit saturation limits.
package pedal_mem_pkg;

  localparam int DEF_ADDR_W   = 16;
  localparam int DEF_SAMPLE_W = 16;

  localparam logic [15:0] SAT_MAX = 16'h7FFF;
  localparam logic [15:0] SAT_MIN = 16'h8000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_OUT
  } dl_state_e;

  typedef enum logic [1:0] {
    MODE_PASS,
    MODE_REC,
    MODE_LOOP
  } dl_mode_e;

endpackage

// File: rtl/sample_sat_add.sv
// Two-operand two's-complement sample add, combinational.
// Wraps by default; clamps to the signed limits when DELAY_SAT_EN is defined.
module sample_sat_add
  import pedal_mem_pkg::*;
#(
  parameter int W = DEF_SAMPLE_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);

  logic [W-1:0] raw;

  assign raw = a + b;

`ifdef DELAY_SAT_EN
  localparam logic [W-1:0] MAX_V = (W == 16) ? W'(SAT_MAX) : {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MIN_V = (W == 16) ? W'(SAT_MIN) : {1'b1, {(W-1){1'b0}}};

  logic pos_ovf;
  logic neg_ovf;

  // Overflow only possible when both operands share a sign the result lost.
  assign pos_ovf = ~a[W-1] & ~b[W-1] &  raw[W-1];
  assign neg_ovf =  a[W-1] &  b[W-1] & ~raw[W-1];

  always_comb begin
    sum = raw;
    if (pos_ovf)      sum = MAX_V;
    else if (neg_ovf) sum = MIN_V;
  end
`else
  assign sum = raw;
`endif

endmodule

// File: rtl/delay_line_ctrl.sv
// Echo/loop delay-line controller: record 4, loop 3, pass-through 2 cycles strobe-to-valid with mem_ready high.
// Memory requests hold until mem_ready; strobes while busy are dropped and set overrun. Option: DELAY_SAT_EN.
module delay_line_ctrl
  import pedal_mem_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int SAMPLE_W = DEF_SAMPLE_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                adc_clock,
  input  logic                record,
  input  logic                loop,
  input  logic [ADDR_W-1:0]   delay_len,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                mem_ready,
  input  logic [SAMPLE_W-1:0] mem_rdata,
  output logic                mem_we,
  output logic                mem_re,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [SAMPLE_W-1:0] mem_wdata,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_valid,
  output logic                busy,
  output logic                overrun
);

  dl_state_e state, state_nxt;
  dl_mode_e  mode;

  logic                adc_q;
  logic                loop_q;
  logic                strobe;
  logic                loop_rise;
  logic                start;
  logic [SAMPLE_W-1:0] smp_q;
  logic [SAMPLE_W-1:0] echo_q;
  logic [ADDR_W-1:0]   dl_q;
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   play_ptr;
  logic [ADDR_W-1:0]   rd_addr;
  logic [ADDR_W-1:0]   rd_inc;
  logic [SAMPLE_W-1:0] mix_sum;
  logic [SAMPLE_W-1:0] out_val;

  assign strobe    = adc_clock & ~adc_q;
  assign loop_rise = loop & ~loop_q;
  assign busy      = (state != ST_IDLE);
  assign start     = (state == ST_IDLE) && strobe;
  assign rd_inc    = rd_addr + ADDR_W'(1);

  sample_sat_add #(.W(SAMPLE_W)) u_mix (
    .a   (smp_q),
    .b   (echo_q),
    .sum (mix_sum)
  );

  always_comb begin
    out_val = smp_q;
    case (mode)
      MODE_REC:  out_val = mix_sum;
      MODE_LOOP: out_val = echo_q;
      default:   out_val = smp_q;
    endcase
  end

  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      ST_IDLE: begin
        if (strobe) begin
          if (loop)        state_nxt = (delay_len == '0) ? ST_OUT : ST_RD;
          else if (record) state_nxt = ST_WR;
          else             state_nxt = ST_OUT;
        end
      end
      ST_WR: begin
        mem_we    = 1'b1;
        mem_addr  = wr_ptr;
        mem_wdata = smp_q;
        if (mem_ready) state_nxt = (dl_q == '0) ? ST_OUT : ST_RD;
      end
      ST_RD: begin
        mem_re   = 1'b1;
        mem_addr = rd_addr;
        if (mem_ready) state_nxt = ST_OUT;
      end
      ST_OUT:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      mode         <= MODE_PASS;
      adc_q        <= 1'b0;
      loop_q       <= 1'b0;
      smp_q        <= '0;
      echo_q       <= '0;
      dl_q         <= '0;
      wr_ptr       <= '0;
      play_ptr     <= '0;
      rd_addr      <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state        <= state_nxt;
      adc_q        <= adc_clock;
      loop_q       <= loop;
      sample_valid <= 1'b0;

      if (strobe && busy) overrun <= 1'b1;

      if (start) begin
        smp_q  <= sample_in;
        dl_q   <= delay_len;
        echo_q <= '0;
        if (loop) begin
          mode <= MODE_LOOP;
          // A loop rise coinciding with the strobe has not reached play_ptr yet.
          rd_addr <= loop_rise ? (wr_ptr - delay_len) : play_ptr;
        end else begin
          mode    <= record ? MODE_REC : MODE_PASS;
          rd_addr <= wr_ptr - delay_len;
        end
      end

      if (state == ST_WR && mem_ready) wr_ptr <= wr_ptr + ADDR_W'(1);

      if (state == ST_RD && mem_ready) begin
        echo_q <= mem_rdata;
        if (mode == MODE_LOOP)
          play_ptr <= (rd_inc == wr_ptr) ? (wr_ptr - dl_q) : rd_inc;
      end else if (loop_rise) begin
        play_ptr <= wr_ptr - delay_len;
      end

      if (state == ST_OUT) begin
        sample_valid <= 1'b1;
        sample_out   <= out_val;
      end
    end
  end

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Randomized self-checking bench for delay_line_ctrl with a behavioural delay-buffer model.
module tb_delay_line_ctrl;

  localparam int AW    = 4;
  localparam int SW    = 16;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          adc_clock = 1'b0;
  logic          record = 1'b0;
  logic          loop = 1'b0;
  logic [AW-1:0] delay_len = '0;
  logic [SW-1:0] sample_in = '0;
  logic          mem_ready = 1'b0;
  logic [SW-1:0] mem_rdata = '0;
  logic          mem_we, mem_re;
  logic [AW-1:0] mem_addr;
  logic [SW-1:0] mem_wdata, sample_out;
  logic          sample_valid, busy, overrun;

  always #5 clk = ~clk;

  delay_line_ctrl #(.ADDR_W(AW), .SAMPLE_W(SW)) dut (
    .clk          (clk),
    .rst          (rst),
    .adc_clock    (adc_clock),
    .record       (record),
    .loop         (loop),
    .delay_len    (delay_len),
    .sample_in    (sample_in),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata),
    .mem_we       (mem_we),
    .mem_re       (mem_re),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory: 0 = always ready, 1 = random ready, 2 = held not-ready.
  logic [SW-1:0] mem [DEPTH];
  int            ready_mode = 0;
  int            wr_seen = 0, rd_seen = 0, req_cycles = 0, valid_cnt = 0;
  logic [AW-1:0] last_waddr = '0, last_raddr = '0;
  logic          both_seen = 1'b0;

  always @(negedge clk) begin
    case (ready_mode)
      0:       mem_ready = 1'b1;
      1:       mem_ready = ($urandom_range(0, 2) != 0);
      default: mem_ready = 1'b0;
    endcase
    mem_rdata = SW'($urandom);
    if (mem_we || mem_re) req_cycles++;
    if (mem_we && mem_re) both_seen = 1'b1;
    if (sample_valid) valid_cnt++;
    if (mem_we && mem_ready) begin
      mem[mem_addr] = mem_wdata;
      last_waddr    = mem_addr;
      wr_seen++;
    end
    if (mem_re && mem_ready) begin
      mem_rdata  = mem[mem_addr];
      last_raddr = mem_addr;
      rd_seen++;
    end
  end

  // Reference model: the delay buffer as the design should see it.
  logic [SW-1:0] mbuf [DEPTH];
  logic [AW-1:0] mwp = '0;
  logic [AW-1:0] mplay = '0;
  bit            prev_loop = 1'b0;

  function automatic logic [SW-1:0] mix(input logic [SW-1:0] a, input logic [SW-1:0] b);
    logic signed [SW+1:0] s;
    s = $signed(a) + $signed(b);
`ifdef DELAY_SAT_EN
    if (s > 32767)  return 16'h7FFF;
    if (s < -32768) return 16'h8000;
`endif
    return s[SW-1:0];
  endfunction

  task automatic model_step(input bit rec, input bit lp, input logic [AW-1:0] dl,
                            input logic [SW-1:0] smp, output logic [SW-1:0] exp_out,
                            output bit did_w, output bit did_r, output logic [AW-1:0] exp_wa,
                            output logic [AW-1:0] exp_ra, output int exp_lat);
    logic [SW-1:0] echo;
    echo = '0; did_w = 1'b0; did_r = 1'b0; exp_wa = '0; exp_ra = '0;
    if (lp) begin
      if (!prev_loop) mplay = mwp - dl;
      if (dl != 0) begin
        exp_ra = mplay;
        echo   = mbuf[mplay];
        did_r  = 1'b1;
        mplay  = mplay + 1'b1;
        if (mplay == mwp) mplay = mwp - dl;
      end
      exp_out = echo;
      exp_lat = (dl != 0) ? 3 : 2;
    end else if (rec) begin
      exp_wa     = mwp;
      did_w      = 1'b1;
      mbuf[mwp]  = smp;
      if (dl != 0) begin
        exp_ra = mwp - dl;
        echo   = mbuf[exp_ra];
        did_r  = 1'b1;
      end
      mwp     = mwp + 1'b1;
      exp_out = mix(smp, echo);
      exp_lat = (dl != 0) ? 4 : 3;
    end else begin
      exp_out = smp;
      exp_lat = 2;
    end
    prev_loop = lp;
  endtask

  task automatic do_sample(input bit rec, input bit lp, input logic [AW-1:0] dl,
                           input logic [SW-1:0] smp, output logic [SW-1:0] got);
    logic [SW-1:0] exp_out;
    logic [AW-1:0] exp_wa, exp_ra;
    bit            did_w, did_r;
    int            exp_lat, lat, w0, r0, q0;
    model_step(rec, lp, dl, smp, exp_out, did_w, did_r, exp_wa, exp_ra, exp_lat);
    @(posedge clk); #1;
    w0 = wr_seen; r0 = rd_seen; q0 = req_cycles;
    record = rec; loop = lp; delay_len = dl; sample_in = smp; adc_clock = 1'b1;
    @(posedge clk); #1;
    adc_clock = 1'b0;
    lat = 1;
    while (!sample_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    got = sample_out;
    if (!sample_valid) begin
      check("valid_timeout", {31'b0, sample_valid}, 32'd1);
    end else begin
      check("sample_out", sample_out, exp_out);
      if (ready_mode == 0) check("latency", lat, exp_lat);
      check("write_count", wr_seen - w0, {31'b0, did_w});
      check("read_count", rd_seen - r0, {31'b0, did_r});
      if (did_w) check("write_addr", last_waddr, exp_wa);
      if (did_r) check("read_addr", last_raddr, exp_ra);
      if (!did_w && !did_r) check("no_mem_req", req_cycles - q0, 0);
      @(posedge clk); #1;
      check("valid_one_cycle", {31'b0, sample_valid}, 0);
      check("idle_after", {31'b0, busy}, 0);
    end
  endtask

  initial begin
    logic [SW-1:0] g;
    logic [SW-1:0] loop_exp [6];
    logic [AW-1:0] a0;
    bit            stable;
    int            v0;
    logic [SW-1:0] e_out;
    logic [AW-1:0] e_wa, e_ra;
    bit            e_w, e_r;
    int            e_lat;

    for (int i = 0; i < DEPTH; i++) begin
      mem[i]  = '0;
      mbuf[i] = '0;
    end

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_overrun", {31'b0, overrun}, 0);
    check("rst_valid", {31'b0, sample_valid}, 0);
    check("rst_we", {31'b0, mem_we}, 0);
    check("rst_re", {31'b0, mem_re}, 0);
    check("rst_addr", {28'b0, mem_addr}, 0);
    check("rst_wdata", {16'b0, mem_wdata}, 0);
    check("rst_out", {16'b0, sample_out}, 0);
    rst = 1'b0;

    do_sample(1'b0, 1'b0, 4'd0, 16'h1234, g);
    check("pass_value", g, 16'h1234);

    for (int i = 1; i <= 8; i++) do_sample(1'b1, 1'b0, 4'd4, SW'(i), g);
    check("record_8th", g, 16'd12);
    check("record_8th_addr", last_waddr, 4'd7);

    loop_exp = '{16'd6, 16'd7, 16'd8, 16'd6, 16'd7, 16'd8};
    for (int i = 0; i < 6; i++) begin
      do_sample(i[0], 1'b1, 4'd3, SW'($urandom), g);
      check("loop_seq", g, loop_exp[i]);
    end
    do_sample(1'b0, 1'b0, 4'd3, 16'h0777, g);

    for (int i = 0; i < 20; i++) do_sample(1'b1, 1'b0, 4'd3, SW'($urandom), g);

    do_sample(1'b1, 1'b0, 4'd0, 16'h0042, g);
    check("dl0_no_echo", g, 16'h0042);

    do_sample(1'b1, 1'b0, 4'd1, 16'h7000, g);
    do_sample(1'b1, 1'b0, 4'd1, 16'h2000, g);
`ifdef DELAY_SAT_EN
    check("mix_sat", g, 16'h7FFF);
`else
    check("mix_wrap", g, 16'h9000);
`endif

    ready_mode = 1;
    for (int i = 0; i < 40; i++) begin
      int m;
      m = $urandom_range(0, 5);
      do_sample((m == 1) || (m == 2) || (m == 5), (m >= 4), AW'($urandom_range(0, 15)),
                SW'($urandom), g);
    end

    // Stall: write held off, a second strobe arrives and must be dropped.
    ready_mode = 0;
    do_sample(1'b0, 1'b0, 4'd0, 16'h0001, g);
    model_step(1'b1, 1'b0, 4'd1, 16'h0055, e_out, e_w, e_r, e_wa, e_ra, e_lat);
    ready_mode = 2;
    @(posedge clk); #1;
    v0 = valid_cnt;
    record = 1'b1; loop = 1'b0; delay_len = 4'd1; sample_in = 16'h0055; adc_clock = 1'b1;
    @(posedge clk); #1;
    adc_clock = 1'b0;
    a0 = mem_addr;
    check("stall_we", {31'b0, mem_we}, 1);
    check("stall_waddr", {28'b0, a0}, {28'b0, e_wa});
    @(posedge clk); #1;
    adc_clock = 1'b1; sample_in = 16'h0666;
    @(posedge clk); #1;
    adc_clock = 1'b0;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (mem_addr !== a0 || mem_we !== 1'b1) stable = 1'b0;
    end
    check("stall_addr_stable", {31'b0, stable}, 1);
    check("overrun_set", {31'b0, overrun}, 1);
    ready_mode = 0;
    repeat (12) @(posedge clk);
    #1;
    check("stall_one_valid", valid_cnt - v0, 1);
    check("stall_out", sample_out, e_out);
    check("overrun_sticky", {31'b0, overrun}, 1);

    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_clears_overrun", {31'b0, overrun}, 0);
    check("rst_idle", {31'b0, busy}, 0);
    rst = 1'b0;
    mwp = '0; mplay = '0; prev_loop = 1'b0;
    do_sample(1'b1, 1'b0, 4'd2, 16'h0100, g);
    check("post_rst_waddr", last_waddr, 4'd0);

    check("we_re_exclusive", {31'b0, both_seen}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
